prism_state_engine: RTL and testbench

- Execution stage directly downstream of the PRISM latch SIT.
- Holds the current-state register and drives the SIT read address.
- Decodes the state-information entry returned combinationally by the SIT, then evaluates a selected input condition or the loop-counter condition.
- On a true condition, jumps to the next state, drives registered outputs and raises an interrupt pulse.
- Run control (start/stop/single-step) comes from the debug register block.

---
 rtl/prism_state_engine.sv | 152 +++++++++++++++
 tb/tb_prism_state_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prism_state_engine.sv
// prism_state_engine: execution stage that walks the PRISM state-information table (SIT).
// Holds the current state, reads its SIT entry combinationally, evaluates either a
// synchronized input condition or the loop-counter condition, and on a true condition
// jumps, updates the loop counter, raises an interrupt pulse and may halt itself.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   sit_raddr       SIT read address (the current state)
//   sit_rdata       SIT entry for sit_raddr, valid in the same cycle
//   sit_busy        SIT loader mid-write; the engine freezes while high
//   in_raw          asynchronous condition inputs (2-flop synchronized)
//   ctl_start/stop  run control pulses (clear / set halted)
//   ctl_step        one evaluation cycle while halted
//   ctl_rst_state   force state and loop counter to 0
//   state_out       current state
//   ctr_out         loop counter
//   halted          engine stopped
//   out_q           registered out_val of the current entry
//   irq             one-cycle interrupt pulse
module prism_state_engine #(
  parameter int unsigned STATES  = 8,
  parameter int unsigned ENTRY_W = 40,
  parameter int unsigned NUM_IN  = 8,
  parameter int unsigned OUT_W   = 8,
  localparam int unsigned S_BITS = $clog2(STATES)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [S_BITS-1:0]  sit_raddr,
  input  logic [ENTRY_W-1:0] sit_rdata,
  input  logic               sit_busy,
  input  logic [NUM_IN-1:0]  in_raw,
  input  logic               ctl_start,
  input  logic               ctl_stop,
  input  logic               ctl_step,
  input  logic               ctl_rst_state,
  output logic [S_BITS-1:0]  state_out,
  output logic [7:0]         ctr_out,
  output logic               halted,
  output logic [OUT_W-1:0]   out_q,
  output logic               irq
);

  // The select field is 3 bits wide; inputs beyond NUM_IN read as 0.
  localparam int unsigned SelW = 8;

  logic [S_BITS-1:0] state_q, state_d;
  logic [7:0]        ctr_q, ctr_d;
  logic              halted_q, halted_d;
  logic [OUT_W-1:0]  outv_q, outv_d;
  logic              irq_q, irq_d;
  logic [NUM_IN-1:0] sync1_q, in_s_q;

  // Entry fields
  logic [2:0]        cond_sel;
  logic              cond_inv, cond_use_ctr;
  logic [2:0]        jump_state;
  logic [7:0]        out_val;
  logic [7:0]        ctr_load;
  logic              ctr_load_on_jump, ctr_dec, halt_on_jump, irq_on_jump;

  logic [SelW-1:0]   in_pad;
  logic              cond, active, taken;

  // Reserved entry bits are intentionally ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^sit_rdata[ENTRY_W-1:28];

  always_comb begin
    cond_sel         = sit_rdata[2:0];
    cond_inv         = sit_rdata[3];
    cond_use_ctr     = sit_rdata[4];
    jump_state       = sit_rdata[7:5];
    out_val          = sit_rdata[15:8];
    ctr_load         = sit_rdata[23:16];
    ctr_load_on_jump = sit_rdata[24];
    ctr_dec          = sit_rdata[25];
    halt_on_jump     = sit_rdata[26];
    irq_on_jump      = sit_rdata[27];
  end

  always_comb begin
    in_pad             = '0;
    in_pad[NUM_IN-1:0] = in_s_q;
  end

  always_comb begin
    cond   = (cond_use_ctr ? (ctr_q == 8'd0) : in_pad[cond_sel]) ^ cond_inv;
    // ctl_step only matters while halted; a running engine evaluates every cycle anyway.
    active = !sit_busy && (!halted_q || ctl_step);
    taken  = active && cond && !ctl_rst_state;

    state_d  = state_q;
    ctr_d    = ctr_q;
    outv_d   = outv_q;
    halted_d = halted_q;
    irq_d    = taken && irq_on_jump;

    if (taken) state_d = jump_state[S_BITS-1:0];

    if (active) begin
      if (taken && ctr_load_on_jump) begin
        ctr_d = ctr_load;
      end else if (ctr_dec && (ctr_q != 8'd0)) begin
        ctr_d = ctr_q - 8'd1;
      end
    end

    if (!sit_busy) outv_d = OUT_W'(out_val);

    // Priority: stop > halt_on_jump > start. Start is ignored while frozen.
    if (ctl_stop || (taken && halt_on_jump)) begin
      halted_d = 1'b1;
    end else if (ctl_start && !sit_busy) begin
      halted_d = 1'b0;
    end

    // State reset wins over everything, even while frozen; halted is untouched.
    if (ctl_rst_state) begin
      state_d = '0;
      ctr_d   = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      ctr_q    <= 8'd0;
      halted_q <= 1'b1;
      outv_q   <= '0;
      irq_q    <= 1'b0;
      sync1_q  <= '0;
      in_s_q   <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      halted_q <= halted_d;
      outv_q   <= outv_d;
      irq_q    <= irq_d;
      sync1_q  <= in_raw;
      in_s_q   <= sync1_q;
    end
  end

  assign sit_raddr = state_q;
  assign state_out = state_q;
  assign ctr_out   = ctr_q;
  assign halted    = halted_q;
  assign out_q     = outv_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_prism_state_engine.sv
// Self-checking bench for prism_state_engine: directed sequences, a table of single-step
// evaluations and a randomized run, all compared against a cycle model of the engine rules.
module tb_prism_state_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  sit_raddr;
  logic [39:0] sit_rdata;
  logic        sit_busy = 1'b0;
  logic [7:0]  in_raw = 8'h00;
  logic        ctl_start = 1'b0, ctl_stop = 1'b0, ctl_step = 1'b0, ctl_rst_state = 1'b0;
  logic [2:0]  state_out;
  logic [7:0]  ctr_out;
  logic        halted;
  logic [7:0]  out_q;
  logic        irq;

  logic [39:0] mem [8];
  assign sit_rdata = mem[sit_raddr];

  prism_state_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sit_raddr     (sit_raddr),
    .sit_rdata     (sit_rdata),
    .sit_busy      (sit_busy),
    .in_raw        (in_raw),
    .ctl_start     (ctl_start),
    .ctl_stop      (ctl_stop),
    .ctl_step      (ctl_step),
    .ctl_rst_state (ctl_rst_state),
    .state_out     (state_out),
    .ctr_out       (ctr_out),
    .halted        (halted),
    .out_q         (out_q),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mchk = 1'b0;

  // Reference model: whole-engine state, advanced once per clock from the rules.
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] ctr;
    logic       hl;
    logic [7:0] ov;
    logic       irq;
    logic [7:0] s1;
    logic [7:0] s2;
  } ms_t;

  localparam ms_t MRst = '{st: 3'd0, ctr: 8'd0, hl: 1'b1, ov: 8'd0, irq: 1'b0,
                           s1: 8'd0, s2: 8'd0};
  ms_t m;

  function automatic ms_t model_next(input ms_t c);
    ms_t         n;
    logic [39:0] e;
    bit          cond, run, tk;
    n = c;
    e = mem[c.st];
    n.s1 = in_raw;
    n.s2 = c.s1;
    cond = (e[4] ? (c.ctr == 8'd0) : c.s2[e[2:0]]) ^ e[3];
    run  = !sit_busy && (!c.hl || ctl_step);
    tk   = run && cond && !ctl_rst_state;
    n.irq = tk && e[27];
    if (tk) n.st = e[7:5];
    if (run) begin
      if (tk && e[24]) n.ctr = e[23:16];
      else if (e[25] && c.ctr > 0) n.ctr = c.ctr - 8'd1;
    end
    if (!sit_busy) n.ov = e[15:8];
    if (ctl_stop || (tk && e[26])) n.hl = 1'b1;
    else if (ctl_start && !sit_busy) n.hl = 1'b0;
    if (ctl_rst_state) begin
      n.st  = 3'd0;
      n.ctr = 8'd0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= MRst;
    else        m <= model_next(m);
  end

  function automatic logic [39:0] mk(input int sel, input int inv, input int uc, input int jmp,
                                     input int ov, input int ld, input int loj, input int dec,
                                     input int hlt, input int iq);
    logic [39:0] e;
    e        = '0;
    e[2:0]   = sel[2:0];
    e[3]     = inv[0];
    e[4]     = uc[0];
    e[7:5]   = jmp[2:0];
    e[15:8]  = ov[7:0];
    e[23:16] = ld[7:0];
    e[24]    = loj[0];
    e[25]    = dec[0];
    e[26]    = hlt[0];
    e[27]    = iq[0];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    chk(nm, {8'd0, state_out, ctr_out, halted, out_q, irq, sit_raddr},
        {8'd0, m.st, m.ctr, m.hl, m.ov, m.irq, m.st});
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    if (mchk) chk_model("model");
  endtask

  typedef struct packed {
    logic [39:0] e;
    logic [7:0]  in;
    logic [2:0]  st;
    logic [7:0]  ctr;
    logic        irq;
  } vec_t;

  vec_t vt [7];

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", {29'd0, state_out}, 32'd0);
    chk("rst_ctr", {24'd0, ctr_out}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_out", {24'd0, out_q}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    #10 rst_n = 1'b1;
    mchk = 1'b1;
    tick();

    // 1: input-condition jump through the synchronizer
    mem[0] = mk(2, 0, 0, 3, 8'hA5, 0, 0, 0, 0, 0);
    mem[3] = mk(0, 0, 0, 0, 8'h3C, 0, 0, 0, 0, 0);
    ctl_start = 1'b1; tick(); ctl_start = 1'b0;
    chk("t1_running", {31'd0, halted}, 32'd0);
    in_raw = 8'h04;
    tick(); chk("t1_sync1", {29'd0, state_out}, 32'd0);
    tick(); chk("t1_sync2", {29'd0, state_out}, 32'd0);
    tick(); chk("t1_jump", {29'd0, state_out}, 32'd3);
    chk("t1_out_old", {24'd0, out_q}, 32'hA5);
    tick(); chk("t1_out_new", {24'd0, out_q}, 32'h3C);
    chk("t1_halted", {31'd0, halted}, 32'd0);

    // 2: counter load then countdown with saturation
    mem[3] = mk(2, 0, 0, 1, 8'h3C, 5, 1, 0, 0, 0);
    mem[1] = mk(0, 1, 1, 1, 8'h11, 0, 0, 1, 0, 0);
    tick(); chk("t2_load_st", {29'd0, state_out}, 32'd1);
    chk("t2_load_ctr", {24'd0, ctr_out}, 32'd5);
    for (int i = 4; i >= 0; i--) begin
      tick(); chk("t2_count", {24'd0, ctr_out}, i);
    end
    tick(); tick(); chk("t2_sat", {24'd0, ctr_out}, 32'd0);
    chk("t2_state", {29'd0, state_out}, 32'd1);

    // 3: irq + halt on jump, then single step
    mem[1] = mk(2, 0, 0, 4, 8'h11, 0, 0, 0, 1, 1);
    mem[4] = mk(2, 0, 0, 6, 8'h44, 0, 0, 0, 0, 0);
    mem[6] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tick(); chk("t3_irq", {31'd0, irq}, 32'd1);
    chk("t3_state", {29'd0, state_out}, 32'd4);
    chk("t3_halted", {31'd0, halted}, 32'd1);
    tick(); chk("t3_irq_pulse", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_raw = 8'($urandom) | 8'h04;
      tick();
    end
    in_raw = 8'h04;
    tick(); tick(); tick();
    chk("t3_frozen", {29'd0, state_out}, 32'd4);
    ctl_step = 1'b1; tick(); ctl_step = 1'b0;
    chk("t3_step", {29'd0, state_out}, 32'd6);
    chk("t3_step_halt", {31'd0, halted}, 32'd1);
    tick(); chk("t3_one_step", {29'd0, state_out}, 32'd6);

    // 4: freeze while the SIT loader is busy
    ctl_start = 1'b1; tick(); ctl_start = 1'b0;
    sit_busy = 1'b1;
    mem[6] = mk(2, 0, 0, 2, 8'h99, 8'h33, 1, 0, 0, 1);
    mem[2] = mk(0, 0, 0, 0, 8'h22, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_busy", {12'd0, state_out, ctr_out, out_q, irq}, {12'd0, 3'd6, 8'd0, 8'h00, 1'b0});
    end
    sit_busy = 1'b0;
    tick(); chk("t4_release", {12'd0, state_out, ctr_out, out_q, irq},
                {12'd0, 3'd2, 8'h33, 8'h99, 1'b1});

    // 5: state reset beats a true condition; stop beats start
    mem[2] = mk(2, 0, 0, 5, 8'h22, 0, 0, 0, 0, 1);
    ctl_rst_state = 1'b1; tick(); ctl_rst_state = 1'b0;
    chk("t5_rst", {20'd0, state_out, ctr_out, irq}, {20'd0, 3'd0, 8'd0, 1'b0});
    ctl_start = 1'b1; ctl_stop = 1'b1; tick(); ctl_start = 1'b0; ctl_stop = 1'b0;
    chk("t5_stop_wins", {31'd0, halted}, 32'd1);

    // 6: asynchronous reset mid-countdown
    mem[0] = mk(0, 0, 1, 5, 8'h00, 3, 1, 0, 0, 0);
    mem[5] = mk(0, 0, 0, 0, 8'h55, 0, 0, 1, 0, 0);
    in_raw = 8'h00;
    ctl_rst_state = 1'b1; tick(); ctl_rst_state = 1'b0;
    ctl_start = 1'b1; tick(); ctl_start = 1'b0;
    tick(); chk("t6_pre", {21'd0, state_out, ctr_out}, {21'd0, 3'd5, 8'd3});
    rst_n = 1'b0;
    #1;
    chk("t6_async", {12'd0, state_out, ctr_out, halted, out_q, irq},
        {12'd0, 3'd0, 8'd0, 1'b1, 8'd0, 1'b0});
    #10 rst_n = 1'b1;
    tick(); chk("t6_after", {28'd0, state_out, halted}, {28'd0, 3'd0, 1'b1});

    // Table: one single-step evaluation of entry 0 from state 0, ctr 0
    vt[0] = '{mk(2, 0, 0, 3, 8'h11, 0, 0, 0, 0, 0) | 40'hFFF0000000, 8'h04, 3'd3, 8'd0, 1'b0};
    vt[1] = '{mk(2, 0, 0, 3, 8'h11, 0, 0, 0, 0, 0), 8'h00, 3'd0, 8'd0, 1'b0};
    vt[2] = '{mk(5, 1, 0, 6, 0, 0, 0, 0, 0, 1), 8'h00, 3'd6, 8'd0, 1'b1};
    vt[3] = '{mk(0, 0, 1, 2, 0, 8'h17, 1, 0, 0, 0), 8'h00, 3'd2, 8'h17, 1'b0};
    vt[4] = '{mk(0, 1, 1, 2, 0, 8'h17, 1, 0, 0, 1), 8'h00, 3'd0, 8'd0, 1'b0};
    vt[5] = '{mk(7, 0, 0, 0, 0, 9, 1, 0, 0, 1), 8'h80, 3'd0, 8'd9, 1'b1};
    vt[6] = '{mk(7, 0, 0, 4, 0, 0, 0, 1, 0, 0), 8'h80, 3'd4, 8'd0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      ctl_rst_state = 1'b1; in_raw = vt[i].in;
      tick(); ctl_rst_state = 1'b0;
      tick(); tick();
      mem[0] = vt[i].e;
      ctl_step = 1'b1; tick(); ctl_step = 1'b0;
      chk($sformatf("vec%0d", i), {19'd0, state_out, ctr_out, irq, halted},
          {19'd0, vt[i].st, vt[i].ctr, vt[i].irq, 1'b1});
    end

    // Randomized run against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) mem[$urandom_range(7)] = {8'($urandom), 32'($urandom)};
      if ($urandom_range(7) == 0) in_raw = 8'($urandom);
      if ($urandom_range(7) == 0) sit_busy = ~sit_busy;
      ctl_start     = ($urandom_range(9) == 0);
      ctl_stop      = ($urandom_range(29) == 0);
      ctl_step      = ($urandom_range(7) == 0);
      ctl_rst_state = ($urandom_range(39) == 0);
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        #1 chk_model("rand_async_rst");
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
